// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: flag/error bit indices and branch-kind codes shared with the decoder
package pc_sequencer_pkg;
  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_S = 1;
  localparam int FLAG_V = 0;
  localparam int ERR_MULTI = 2;
  localparam int ERR_OVF = 1;
  localparam int ERR_UNF = 0;
  localparam int NUM_STROBES = 12;
  typedef enum logic [3:0] {
    K_NONE, K_B, K_BR, K_BZ, K_BNZ, K_BCY, K_BNCY,
    K_BS, K_BNS, K_BV, K_BNV, K_CALL, K_RET
  } br_kind_e;
  function automatic logic multi_hot(input logic [NUM_STROBES-1:0] v);
    return (v & (v - 1'b1)) != '0;
  endfunction
endpackage

// File: rtl/pc_sequencer_ras.sv
// ras_stack: circular return-address LIFO; a push when full overwrites the oldest entry
module ras_stack #(
  parameter int W = 32,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         full,
  output logic         ovf,
  output logic         unf
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] sp, sp_dec;
  logic [PW:0] cnt;
  assign sp_dec = sp - 1'b1;
  assign top = mem[sp_dec];
  assign empty = cnt == '0;
  assign full = cnt == (PW+1)'(DEPTH);
  assign ovf = push & full;
  assign unf = pop & empty;
  // storage: write at the free slot, wrapping over the oldest entry
  always_ff @(posedge clk)
    if (push) mem[sp] <= din;
  // pointer and occupancy; an underflowing pop leaves both untouched
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sp <= '0;
      cnt <= '0;
    end else if (push) begin
      sp <= sp + 1'b1;
      cnt <= full ? cnt : cnt + 1'b1;
    end else if (pop && !empty) begin
      sp <= sp_dec;
      cnt <= cnt - 1'b1;
    end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC stage with flags, return stack and redirect/flush; PC_SEQ_BRANCH_CNT_EN adds a taken-branch counter
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int RAS_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              b,
  input  logic              br,
  input  logic              bz,
  input  logic              bnz,
  input  logic              bcy,
  input  logic              bncy,
  input  logic              bs,
  input  logic              bns,
  input  logic              bv,
  input  logic              bnv,
  input  logic              call,
  input  logic              ret,
  input  logic [ADDR_W-1:0] target,
  input  logic [ADDR_W-1:0] rs_val,
  input  logic              flag_we,
  input  logic              alu_z,
  input  logic              alu_c,
  input  logic              alu_s,
  input  logic              alu_v,
  output logic [ADDR_W-1:0] pc,
  output logic [3:0]        flags,
  output logic              redirect,
  output logic              flush,
  output logic              ras_empty,
  output logic              ras_full,
  output logic [2:0]        err,
  output logic [15:0]       br_taken_cnt
);
  logic [NUM_STROBES-1:0] strobes;
  logic cond, take, push, pop, ovf, unf, multi;
  logic [ADDR_W-1:0] pc_inc, tgt, ras_top;
  assign strobes = {ret, call, br, b, bz, bnz, bcy, bncy, bs, bns, bv, bnv};
  assign multi = multi_hot(strobes);
  assign pc_inc = pc + 1'b1;
  assign push = call & ~ret & ~stall;
  assign pop = ret & ~stall;
  assign redirect = take;
  // winner selection: ret > call > br > b > conditionals, evaluated on registered flags
  always_comb begin
    cond = bz   ?  flags[FLAG_Z] :
           bnz  ? !flags[FLAG_Z] :
           bcy  ?  flags[FLAG_C] :
           bncy ? !flags[FLAG_C] :
           bs   ?  flags[FLAG_S] :
           bns  ? !flags[FLAG_S] :
           bv   ?  flags[FLAG_V] :
           bnv  ? !flags[FLAG_V] : 1'b0;
    take = ret ? !ras_empty : (call | br | b) ? 1'b1 : cond;
    tgt = ret ? ras_top : (br && !call) ? rs_val : target;
  end
  ras_stack #(.W(ADDR_W), .DEPTH(RAS_DEPTH)) u_ras (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .din(pc_inc),
    .top(ras_top), .empty(ras_empty), .full(ras_full), .ovf(ovf), .unf(unf)
  );
  // architectural state: pc, flags, sticky errors; flush follows an acted-on redirect
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc <= RESET_PC;
      flags <= '0;
      flush <= 1'b0;
      err <= '0;
    end else begin
      flush <= redirect & ~stall;
      if (!stall) begin
        pc <= redirect ? tgt : pc_inc;
        if (flag_we) flags <= {alu_z, alu_c, alu_s, alu_v};
        err <= err | {multi, ovf, unf};
      end
    end
`ifdef PC_SEQ_BRANCH_CNT_EN
  logic [15:0] cnt_q;
  // saturating count of acted-on redirects
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else if (!stall && redirect && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 1'b1;
  assign br_taken_cnt = cnt_q;
`else
  assign br_taken_cnt = '0;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed self-checking bench for pc_sequencer (honours PC_SEQ_BRANCH_CNT_EN)
module tb_pc_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, stall = 1'b0;
  logic b, br, bz, bnz, bcy, bncy, bs, bns, bv, bnv, call, ret;
  logic [31:0] target = '0, rs_val = '0;
  logic flag_we = 1'b0, alu_z = 1'b0, alu_c = 1'b0, alu_s = 1'b0, alu_v = 1'b0;
  logic [31:0] pc;
  logic [3:0] flags;
  logic redirect, flush, ras_empty, ras_full;
  logic [2:0] err;
  logic [15:0] br_taken_cnt;
  int vecs = 0, errs = 0;
  logic [31:0] exp_pc;

  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .b(b), .br(br), .bz(bz), .bnz(bnz), .bcy(bcy), .bncy(bncy), .bs(bs), .bns(bns),
    .bv(bv), .bnv(bnv), .call(call), .ret(ret),
    .target(target), .rs_val(rs_val), .flag_we(flag_we),
    .alu_z(alu_z), .alu_c(alu_c), .alu_s(alu_s), .alu_v(alu_v),
    .pc(pc), .flags(flags), .redirect(redirect), .flush(flush),
    .ras_empty(ras_empty), .ras_full(ras_full), .err(err), .br_taken_cnt(br_taken_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    {b, br, bz, bnz, bcy, bncy, bs, bns, bv, bnv, call, ret} = '0;
    flag_we = 1'b0; alu_z = 1'b0; alu_c = 1'b0; alu_s = 1'b0; alu_v = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_pc"}, pc, 32'h0);
    chk({tag, "_flags"}, 32'(flags), 32'h0);
    chk({tag, "_flush"}, 32'(flush), 32'h0);
    chk({tag, "_empty"}, 32'(ras_empty), 32'h1);
    chk({tag, "_full"}, 32'(ras_full), 32'h0);
    chk({tag, "_err"}, 32'(err), 32'h0);
    chk({tag, "_cnt"}, 32'(br_taken_cnt), 32'h0);
  endtask

  initial begin
    clr();
    #3;
    chk_reset("rst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("idle_pc0", pc, 32'h0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk($sformatf("idle_pc%0d", i), pc, 32'(i));
      chk("idle_flush", 32'(flush), 32'h0);
    end
    repeat (5) tick();
    chk("pc10", pc, 32'd10);
    // latch Z, then bz uses it
    flag_we = 1'b1; alu_z = 1'b1;
    tick();
    clr();
    chk("flags_z", 32'(flags), 32'h8);
    bz = 1'b1; target = 32'h40;
    #1 chk("bz_redirect", 32'(redirect), 32'h1);
    tick();
    clr();
    chk("bz_pc", pc, 32'h40);
    chk("bz_flush1", 32'(flush), 32'h1);
    tick();
    chk("bz_flush0", 32'(flush), 32'h0);
    chk("bz_pc_seq", pc, 32'h41);
    // back to 10, bnz not taken with Z set
    b = 1'b1; target = 32'd10;
    tick();
    clr();
    flag_we = 1'b1; alu_z = 1'b1;
    tick();
    clr();
    bnz = 1'b1; target = 32'h40;
    #1 chk("bnz_redirect", 32'(redirect), 32'h0);
    tick();
    chk("bnz_pc", pc, 32'd12);
    chk("bnz_flush", 32'(flush), 32'h0);
    // bnz with same-cycle flag_we clearing Z: old Z=1 still wins
    flag_we = 1'b1; alu_z = 1'b0;
    #1 chk("bnz_oldflag_redirect", 32'(redirect), 32'h0);
    tick();
    chk("bnz_oldflag_pc", pc, 32'd13);
    chk("bnz_newflags", 32'(flags), 32'h0);
    flag_we = 1'b0;
    #1 chk("bnz_now_taken", 32'(redirect), 32'h1);
    tick();
    clr();
    chk("bnz_taken_pc", pc, 32'h40);
    // br uses rs_val
    br = 1'b1; rs_val = 32'h20; target = 32'h999;
    tick();
    clr();
    chk("br_pc", pc, 32'h20);
    // call / ret
    call = 1'b1; target = 32'h100;
    #1 chk("call_redirect", 32'(redirect), 32'h1);
    tick();
    clr();
    chk("call_pc", pc, 32'h100);
    chk("call_nonempty", 32'(ras_empty), 32'h0);
    repeat (5) tick();
    chk("pc105", pc, 32'h105);
    ret = 1'b1;
    #1 chk("ret_redirect", 32'(redirect), 32'h1);
    tick();
    clr();
    chk("ret_pc", pc, 32'h21);
    chk("ret_empty", 32'(ras_empty), 32'h1);
    // nine nested calls into depth-8 stack
    for (int i = 0; i < 9; i++) begin
      call = 1'b1; target = 32'h200 + 32'(i) * 32'h10;
      tick();
      clr();
      chk($sformatf("ncall_pc%0d", i), pc, 32'h200 + 32'(i) * 32'h10);
      if (i == 7) chk("ras_full8", 32'(ras_full), 32'h1);
    end
    chk("ovf_full", 32'(ras_full), 32'h1);
    chk("ovf_err", 32'(err), 32'h2);
    for (int k = 0; k < 8; k++) begin
      ret = 1'b1;
      tick();
      clr();
      chk($sformatf("nret_pc%0d", k), pc, 32'h271 - 32'(k) * 32'h10);
    end
    chk("nret_empty", 32'(ras_empty), 32'h1);
    chk("nret_err", 32'(err), 32'h2);
    ret = 1'b1;
    #1 chk("unf_redirect", 32'(redirect), 32'h0);
    tick();
    clr();
    chk("unf_pc", pc, 32'h202);
    chk("unf_err", 32'(err), 32'h3);
    chk("unf_empty", 32'(ras_empty), 32'h1);
    // multiple strobes
    b = 1'b1; bz = 1'b1; target = 32'h80;
    tick();
    clr();
    chk("multi_pc", pc, 32'h80);
    chk("multi_err", 32'(err), 32'h7);
    chk("multi_flush", 32'(flush), 32'h1);
    // stall with b active
    stall = 1'b1; b = 1'b1; target = 32'h300;
    #1 chk("stall_redirect", 32'(redirect), 32'h1);
    tick();
    chk("stall_pc", pc, 32'h80);
    chk("stall_flush", 32'(flush), 32'h0);
    stall = 1'b0;
    clr();
    // wrap from all-ones
    b = 1'b1; target = 32'hFFFF_FFFF;
    tick();
    clr();
    chk("wrap_pc_max", pc, 32'hFFFF_FFFF);
    tick();
    chk("wrap_pc0", pc, 32'h0);
    chk("wrap_err", 32'(err), 32'h7);
    // async reset mid-run with flush/flags active
    b = 1'b1; target = 32'h300; flag_we = 1'b1; alu_c = 1'b1;
    tick();
    clr();
    chk("pre_rst_pc", pc, 32'h300);
    chk("pre_rst_flags", 32'(flags), 32'h4);
    chk("pre_rst_flush", 32'(flush), 32'h1);
    #2 rst_n = 1'b0;
    #1 chk_reset("midrst");
    #1 rst_n = 1'b1;
    // 3 taken, 2 not-taken (Z clear after reset)
    for (int i = 0; i < 3; i++) begin
      b = 1'b1; target = 32'h50;
      tick();
      clr();
    end
    for (int i = 0; i < 2; i++) begin
      bz = 1'b1; target = 32'h90;
      tick();
      clr();
    end
    chk("cnt_pc", pc, 32'h52);
`ifdef PC_SEQ_BRANCH_CNT_EN
    chk("cnt_value", 32'(br_taken_cnt), 32'd3);
`else
    chk("cnt_value", 32'(br_taken_cnt), 32'd0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Next-PC stage directly downstream of the instruction decoder.
- Consumes the one-hot branch/call/return strobes and the ALU condition flags, and owns the program counter, the architectural flag register (Z/C/S/V) and a hardware return-address stack (RAS).
- Drives the fetch address to instruction memory and issues a one-cycle flush pulse after every taken redirect.

Parameters:
- ADDR_W, 32, PC and target width.
- RAS_DEPTH, 8, return-address stack entries (power of two, min 2).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  freeze all state this cycle.
- b, br, bz, bnz, bcy, bncy, bs, bns, bv, bnv, call, ret  in  1 each  decoder strobes, expected one-hot or all-zero.
- target  in  ADDR_W  absolute target for the b-family and call.
- rs_val  in  ADDR_W  register value, used as target by br.
- flag_we  in  1  ALU op completed; latch flags.
- alu_z, alu_c, alu_s, alu_v  in  1 each  ALU zero/carry/sign/overflow.
- pc  out  ADDR_W  current fetch address.
- flags  out  4  registered {Z,C,S,V}.
- redirect  out  1  combinational: taken control transfer this cycle.
- flush  out  1  registered: pulse one cycle after a taken redirect.
- ras_empty, ras_full  out  1 each  stack status.
- err  out  3  sticky {ctl_multi, ras_ovf, ras_unf}.
- br_taken_cnt  out  16  taken-branch count (optional feature).

Behaviour:
- Reset (async assert, sync-released use): pc=RESET_PC, flags=0, flush=0, RAS pointer=0, ras_empty=1, ras_full=0, err=0, br_taken_cnt=0.
- Word addressing: sequential next PC is pc+1, modulo 2^ADDR_W. pc=all-ones wraps to 0 with no error.
- Condition evaluation uses the registered flags (from the previous flag_we), never the same-cycle alu_* inputs.
  - bz: Z. bnz: !Z. bcy: C. bncy: !C. bs: S. bns: !S. bv: V. bnv: !V.
- Targets:
  - b, call, and taken conditionals: target.
  - br: rs_val.
  - ret: popped RAS top.
- redirect is the taken condition. Next pc is the target if redirect, else pc+1. flush is registered from redirect.
- call: push pc+1, then jump to target.
  - Push when full overwrites the oldest entry (circular), keeps ras_full=1 and sets err[1].
- ret: pop and jump to the popped entry.
  - Pop when empty: pc<=pc+1, redirect=0, err[0] set, pointer unchanged.
- Multiple strobes asserted:
  - Priority ret > call > br > b > conditionals (bz..bnv in listed order).
  - Set err[2]; only the winner acts.
- flag_we in the same cycle as a conditional: the branch uses the old flags; the new flags are latched at the edge.
- stall=1: pc, flags, RAS, counter and err all hold. flush is forced to 0. redirect still reflects the combinational evaluation but is not acted on.
- err bits are sticky until reset.

Optional Feature:
- PC_SEQ_BRANCH_CNT_EN defined:
  - br_taken_cnt increments on every unstalled cycle with redirect=1, ret included.
  - Saturates at 0xFFFF.
- Undefined: br_taken_cnt is tied to 0 and no counter flops exist.

Decomposition:
- Shared package holds:
  - Flag bit indices FLAG_Z=3, FLAG_C=2, FLAG_S=1, FLAG_V=0.
  - err bit indices.
  - Opcode/branch-kind constants shared with the decoder.
- One sub-module is natural: ras_stack (circular LIFO with push/pop, full/empty and overflow/underflow strobes).

Test Plan:
- Reset then 5 idle cycles -> pc steps 0,1,2,3,4,5; flags=0; flush=0.
- flag_we with alu_z=1 at pc=10, then bz with target=0x40 at pc=11 -> redirect=1; pc=0x40 next cycle; flush=1 for exactly one cycle. Same sequence with bnz -> pc=12.
- call target=0x100 at pc=0x20, then ret at pc=0x105 -> pc=0x100, then 0x21; ras_empty returns to 1.
- Nine nested calls with RAS_DEPTH=8 -> err[1]=1; eight rets return correct addresses; ninth ret -> err[0]=1 and pc=pc+1.
- b and bz asserted together, target=0x80 -> pc=0x80; err[2]=1. stall=1 with b active -> pc unchanged and flush=0.
- PC_SEQ_BRANCH_CNT_EN defined, 3 taken and 2 not-taken branches -> br_taken_cnt=3. Assert rst_n low mid-run -> all outputs return to reset values immediately.
